gcm_result_scroller: RTL and testbench
======================================

Name: gcm_result_scroller

Overview:
Sits directly downstream of gcm_aes and directly upstream of the 7-segment display driver.
- Captures the 128-bit tag and 128-bit cipher text once, on the first rising edge of tag_ready.
- Holds the captured values until re-armed.
- Steps through the 16 byte lanes of both words, presenting {tag byte k, cipher byte k} as the display's 16-bit input word.
- This replaces the combinational freeze logic at top level with a clean registered capture and scroll.

Parameters:
- TICK_DIV, default 50_000_000: clk cycles per scroll step; legal values are ≥2. Benches use 4.
- LAST_IDX, default 15: highest byte index displayed. The index wraps from LAST_IDX to 0. Legal range is 0..15.

Ports:
- clk, input, 1: system clock (clk_out domain).
- i_reset_n, input, 1: asynchronous active-low reset.
- i_tag_ready, input, 1: tag-valid level from gcm_aes.
- i_tag, input, [0:127]: GCM tag; byte k is bits [8k:8k+7].
- i_cipher_text, input, [0:127]: cipher text; byte k is bits [8k:8k+7].
- i_rearm, input, 1: synchronous pulse that discards the capture and waits for the next tag_ready rise.
- o_disp, output, [0:15]: {tag byte k, cipher byte k}, fed to display i_x.
- o_index, output, [3:0]: current byte index k.
- o_captured, output, 1: high while a capture is held.

Behaviour:
Reset (i_reset_n=0, asynchronous):
- State is IDLE; tag_reg and ct_reg are 0; o_disp=0, o_index=0, o_captured=0.
- Tick counter is 0; rdy_prev is 0.

Edge detect:
- rdy_prev <= i_tag_ready on every clock, in every state.
- rise = i_tag_ready & ~rdy_prev.

IDLE state:
- o_captured=0, o_disp=0, o_index=0.
- On rise: load tag_reg<=i_tag and ct_reg<=i_cipher_text; set index=0 and counter=0; go to SCROLL.
- Outputs are registered. o_disp shows byte 0 and o_captured=1 immediately after the capturing edge, so capture latency is 1 clock.

SCROLL state:
- o_disp = {tag_reg[8k:8k+7], ct_reg[8k:8k+7]}, where k = o_index.
- The counter increments every clock. When counter == TICK_DIV-1: counter <= 0 and index <= (index==LAST_IDX) ? 0 : index+1.
- Result: each byte is shown for exactly TICK_DIV cycles.
- Further rises of i_tag_ready are ignored (first capture wins). Changes on i_tag or i_cipher_text have no effect.

i_rearm:
- Accepted in any state: return to IDLE; clear o_captured, o_disp, o_index, counter, tag_reg and ct_reg.
- If i_rearm and a rise occur on the same edge, i_rearm wins and the capture is NOT taken. rdy_prev still updates, so that rise is lost; a capture requires a fresh low-to-high transition.

i_tag_ready already high when reset releases:
- rdy_prev resets to 0, so the first sampled edge counts as a rise and captures.

Reset during SCROLL:
- Asynchronous return to the reset values above; no partial output.

Widths:
- Counter is $clog2(TICK_DIV) bits, unsigned.
- Index is 4 bits; it never exceeds LAST_IDX.

Optional Feature:
Macro GCM_SCROLL_MANUAL_EN.
- Defined:
  - Adds input port i_step (1 bit, asynchronous pushbutton).
  - i_step passes through a 2-flop synchronizer, then a rising-edge detector.
  - Each detected step advances the index by 1 with the same wrap rule.
  - The TICK_DIV timer is removed, and the index does not advance on its own.
  - Step edges in IDLE are ignored.
  - A step edge coinciding with i_rearm is ignored.
- Undefined:
  - No i_step port.
  - Timer-driven scrolling as described above.

Test Plan (TICK_DIV=4, LAST_IDX=15):
1. Reset, then rise i_tag_ready with i_tag=128'h00112233_44556677_8899AABB_CCDDEEFF and i_cipher_text=128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F.
   - One clock later: o_captured=1, o_index=0, o_disp=16'h00F0.
   - After 4 clocks: o_index=1, o_disp=16'h11E1.
2. Continue scroll from scenario 1 for 64 clocks.
   - o_index returns to 0, o_disp=16'h00F0.
   - Index 15 shows 16'hFF0F for exactly 4 cycles.
3. While in SCROLL, drop then re-raise i_tag_ready with i_tag=all-ones.
   - o_disp is unchanged; captured data is retained.
4. Pulse i_rearm on the same edge as a tag_ready rise.
   - Result: o_captured=0, o_disp=0.
   - Hold i_tag_ready high for 10 clocks: still no capture.
   - Drop and re-raise it: capture occurs one clock later.
5. Assert i_reset_n=0 mid-scroll at index 7, between clock edges.
   - o_disp=0, o_index=0, o_captured=0 immediately, with no clock needed.
   - Release reset with i_tag_ready held high: capture on the first edge.
6. With GCM_SCROLL_MANUAL_EN defined, after a capture:
   - Apply 3 i_step presses, each held ≥3 clocks → o_index=3.
   - 100 idle clocks → o_index stays 3.
   - A step press in IDLE → o_index stays 0.

Source files
------------

// File: rtl/gcm_result_scroller.sv
// gcm_result_scroller
//
// Captures the gcm_aes tag and cipher text on the first rising edge of
// i_tag_ready. The captured pair is held until i_rearm. While the pair is
// held, the block steps through its 16 byte lanes and presents
// {tag byte k, cipher byte k} to the 7-segment display driver.
//
// Byte numbering is MSB-first: byte 0 is bits [0:7] of the [0:127] ports.
//
// Parameters
//   TICK_DIV : clk cycles per scroll step (>= 2)
//   LAST_IDX : highest byte index shown; the index wraps to 0 after it (0..15)
//
// Ports
//   clk           : system clock (clk_out domain)
//   i_reset_n     : asynchronous active-low reset
//   i_tag_ready   : tag-valid level from gcm_aes
//   i_tag         : 128-bit GCM tag
//   i_cipher_text : 128-bit cipher text
//   i_rearm       : synchronous pulse; drop the capture and wait for a new rise
//   i_step        : manual step pushbutton (only with GCM_SCROLL_MANUAL_EN)
//   o_disp        : {tag byte k, cipher byte k}, registered
//   o_index       : current byte index k, registered
//   o_captured    : high while a capture is held, registered
//
// Build option
//   GCM_SCROLL_MANUAL_EN : when defined, the scroll timer is removed and the
//                          index advances only on synchronized i_step presses.
`timescale 1ns/1ps

module gcm_result_scroller #(
    parameter int TICK_DIV = 50_000_000,
    parameter int LAST_IDX = 15
) (
    input  logic         clk,
    input  logic         i_reset_n,
    input  logic         i_tag_ready,
    input  logic [0:127] i_tag,
    input  logic [0:127] i_cipher_text,
    input  logic         i_rearm,
`ifdef GCM_SCROLL_MANUAL_EN
    input  logic         i_step,
`endif
    output logic [0:15]  o_disp,
    output logic [3:0]   o_index,
    output logic         o_captured
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SCROLL = 1'b1;

    localparam logic [3:0] LAST_K = 4'(LAST_IDX);

`ifndef GCM_SCROLL_MANUAL_EN
    localparam int             CW      = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);
`endif

    // Internal storage is kept descending; the port assignment maps port
    // bit 0 (MSB of byte 0) onto bit 127 here.
    logic [0:0]   state_r;
    logic [0:0]   state_nxt_s;
    logic [127:0] tag_r;
    logic [127:0] tag_nxt_s;
    logic [127:0] ct_r;
    logic [127:0] ct_nxt_s;
    logic [127:0] tag_in_s;
    logic [127:0] ct_in_s;
    logic [3:0]   idx_r;
    logic [3:0]   idx_nxt_s;
    logic [15:0]  disp_r;
    logic [15:0]  disp_nxt_s;
    logic         cap_r;
    logic         cap_nxt_s;
    logic         rdy_prev_r;
    logic         rise_s;

`ifdef GCM_SCROLL_MANUAL_EN
    logic         step_meta_r;
    logic         step_sync_r;
    logic         step_prev_r;
    logic         step_rise_s;
`else
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
`endif

    // Byte k of a word, MSB-first numbering.
    function automatic logic [7:0] byte_sel(input logic [127:0] w, input logic [3:0] k);
        logic [6:0] hi;
        hi = 7'd127 - {k, 3'b000};
        byte_sel = w[hi -: 8];
    endfunction

    // Next index with wrap after LAST_IDX.
    function automatic logic [3:0] next_index(input logic [3:0] k);
        if (k == LAST_K) begin
            next_index = 4'd0;
        end else begin
            next_index = k + 4'd1;
        end
    endfunction

    assign tag_in_s = i_tag;
    assign ct_in_s  = i_cipher_text;

    // rdy_prev_r is updated unconditionally, so a rise swallowed by i_rearm
    // is lost and a capture needs a fresh low-to-high transition.
    assign rise_s = i_tag_ready & ~rdy_prev_r;

`ifdef GCM_SCROLL_MANUAL_EN
    assign step_rise_s = step_sync_r & ~step_prev_r;
`endif

    // Next-state, capture and scroll logic.
    always_comb begin
        state_nxt_s = state_r;
        tag_nxt_s   = tag_r;
        ct_nxt_s    = ct_r;
        idx_nxt_s   = idx_r;
`ifndef GCM_SCROLL_MANUAL_EN
        cnt_nxt_s   = cnt_r;
`endif
        if (i_rearm) begin
            state_nxt_s = ST_IDLE;
            tag_nxt_s   = 128'd0;
            ct_nxt_s    = 128'd0;
            idx_nxt_s   = 4'd0;
`ifndef GCM_SCROLL_MANUAL_EN
            cnt_nxt_s   = '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_nxt_s = ST_SCROLL;
                        tag_nxt_s   = tag_in_s;
                        ct_nxt_s    = ct_in_s;
                        idx_nxt_s   = 4'd0;
`ifndef GCM_SCROLL_MANUAL_EN
                        cnt_nxt_s   = '0;
`endif
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SCROLL: begin
                    // Further rises of i_tag_ready are ignored here: first capture wins.
`ifdef GCM_SCROLL_MANUAL_EN
                    if (step_rise_s) begin
                        idx_nxt_s = next_index(idx_r);
                    end else begin
                        idx_nxt_s = idx_r;
                    end
`else
                    if (cnt_r == CNT_MAX) begin
                        cnt_nxt_s = '0;
                        idx_nxt_s = next_index(idx_r);
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
`endif
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    tag_nxt_s   = 128'd0;
                    ct_nxt_s    = 128'd0;
                    idx_nxt_s   = 4'd0;
`ifndef GCM_SCROLL_MANUAL_EN
                    cnt_nxt_s   = '0;
`endif
                end
            endcase
        end

        // Outputs are computed from the next state so the registered display
        // shows byte 0 right after the capturing edge.
        if (state_nxt_s == ST_SCROLL) begin
            disp_nxt_s = {byte_sel(tag_nxt_s, idx_nxt_s), byte_sel(ct_nxt_s, idx_nxt_s)};
            cap_nxt_s  = 1'b1;
        end else begin
            disp_nxt_s = 16'd0;
            cap_nxt_s  = 1'b0;
        end
    end

    // State, capture registers and registered outputs.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            tag_r      <= 128'd0;
            ct_r       <= 128'd0;
            idx_r      <= 4'd0;
            disp_r     <= 16'd0;
            cap_r      <= 1'b0;
            rdy_prev_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            tag_r      <= tag_nxt_s;
            ct_r       <= ct_nxt_s;
            idx_r      <= idx_nxt_s;
            disp_r     <= disp_nxt_s;
            cap_r      <= cap_nxt_s;
            rdy_prev_r <= i_tag_ready;
        end
    end

`ifdef GCM_SCROLL_MANUAL_EN
    // Two-flop synchronizer and edge-detect history for the step pushbutton.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            step_meta_r <= 1'b0;
            step_sync_r <= 1'b0;
            step_prev_r <= 1'b0;
        end else begin
            step_meta_r <= i_step;
            step_sync_r <= step_meta_r;
            step_prev_r <= step_sync_r;
        end
    end
`else
    // Scroll-step timer.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`endif

    assign o_disp     = disp_r;
    assign o_index    = idx_r;
    assign o_captured = cap_r;

endmodule

// File: tb/tb_gcm_result_scroller.sv
`timescale 1ns/1ps

module tb_gcm_result_scroller;

    localparam int TICK_DIV = 4;
    localparam int LAST_IDX = 15;

    logic         clk = 1'b0;
    logic         i_reset_n;
    logic         i_tag_ready;
    logic [127:0] i_tag;
    logic [127:0] i_cipher_text;
    logic         i_rearm;
    logic         i_step;
    logic [15:0]  o_disp;
    logic [3:0]   o_index;
    logic         o_captured;

    logic [127:0] tag_v;
    logic [127:0] ct_v;

    // Scoreboard: expected {captured, index, disp} plus a check name.
    logic [20:0]  exp_q[$];
    string        name_q[$];
    event         chk_ev;
    int           total = 0;
    int           bad   = 0;

    gcm_result_scroller #(
        .TICK_DIV(TICK_DIV),
        .LAST_IDX(LAST_IDX)
    ) dut (
        .clk           (clk),
        .i_reset_n     (i_reset_n),
        .i_tag_ready   (i_tag_ready),
        .i_tag         (i_tag),
        .i_cipher_text (i_cipher_text),
        .i_rearm       (i_rearm),
`ifdef GCM_SCROLL_MANUAL_EN
        .i_step        (i_step),
`endif
        .o_disp        (o_disp),
        .o_index       (o_index),
        .o_captured    (o_captured)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic cap, input logic [3:0] idx,
                              input logic [15:0] disp);
        exp_q.push_back({cap, idx, disp});
        name_q.push_back(nm);
    endtask

    // Expected display word for byte k of the scenario-1 vectors.
    function automatic logic [15:0] model_disp(input int k);
        int hi;
        hi = 127 - 8 * k;
        return {tag_v[hi -: 8], ct_v[hi -: 8]};
    endfunction

    // Monitor: compares on each falling edge, or immediately on chk_ev.
    initial begin
        logic [20:0] e;
        logic [20:0] got;
        string       nm;
        forever begin
            @(negedge clk or chk_ev);
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {o_captured, o_index, o_disp};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got cap=%0b idx=%0d disp=%h, expected cap=%0b idx=%0d disp=%h",
                             nm, got[20], got[19:16], got[15:0], e[20], e[19:16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, expected end before 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        i_reset_n     = 1'b0;
        i_tag_ready   = 1'b0;
        i_tag         = 128'd0;
        i_cipher_text = 128'd0;
        i_rearm       = 1'b0;
        i_step        = 1'b0;
        tag_v = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        ct_v  = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

        tick();
        tick();
        expect_out("reset", 1'b0, 4'd0, 16'h0000);
        i_reset_n = 1'b1;
        tick();
        expect_out("idle", 1'b0, 4'd0, 16'h0000);

        // Scenario 1: capture
        i_tag         = tag_v;
        i_cipher_text = ct_v;
        i_tag_ready   = 1'b1;
        tick();
        expect_out("cap_latency", 1'b1, 4'd0, 16'h00F0);

`ifdef GCM_SCROLL_MANUAL_EN
        // Scenario 6: manual stepping
        for (int p = 0; p < 3; p++) begin
            i_step = 1'b1;
            repeat (4) tick();
            i_step = 1'b0;
            repeat (4) tick();
        end
        expect_out("manual_3steps", 1'b1, 4'd3, 16'h33C3);
        repeat (100) tick();
        expect_out("manual_hold", 1'b1, 4'd3, 16'h33C3);
        i_rearm = 1'b1;
        tick();
        expect_out("manual_rearm", 1'b0, 4'd0, 16'h0000);
        i_rearm = 1'b0;
        i_step  = 1'b1;
        repeat (4) tick();
        i_step  = 1'b0;
        repeat (4) tick();
        expect_out("manual_idle_step", 1'b0, 4'd0, 16'h0000);
`else
        for (int c = 1; c <= 3; c++) begin
            tick();
            expect_out("hold_byte0", 1'b1, 4'd0, 16'h00F0);
        end
        tick();
        expect_out("step_1", 1'b1, 4'd1, 16'h11E1);

        // Scenario 2: full scroll and wrap
        for (int c = 5; c <= 70; c++) begin
            tick();
            k = (c / TICK_DIV) % (LAST_IDX + 1);
            if (c == 64) begin
                expect_out("wrap", 1'b1, 4'd0, 16'h00F0);
            end else if (k == 15) begin
                expect_out("idx15_hold", 1'b1, 4'd15, 16'hFF0F);
            end else begin
                expect_out("scroll", 1'b1, 4'(k), model_disp(k));
            end
        end

        // Scenario 3: second rise with new data is ignored
        i_tag_ready = 1'b0;
        tick();
        expect_out("ready_low", 1'b1, 4'd1, model_disp(1));
        i_tag         = {128{1'b1}};
        i_cipher_text = {128{1'b1}};
        i_tag_ready   = 1'b1;
        for (int c = 72; c <= 75; c++) begin
            tick();
            expect_out("ignore_rise", 1'b1, 4'd2, model_disp(2));
        end

        // Scenario 4: rearm beats a coincident rise
        i_tag_ready = 1'b0;
        tick();
        expect_out("pre_rearm", 1'b1, 4'd3, model_disp(3));
        i_tag         = tag_v;
        i_cipher_text = ct_v;
        i_tag_ready   = 1'b1;
        i_rearm       = 1'b1;
        tick();
        expect_out("rearm_wins", 1'b0, 4'd0, 16'h0000);
        i_rearm = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            expect_out("no_cap_held", 1'b0, 4'd0, 16'h0000);
        end
        i_tag_ready = 1'b0;
        tick();
        expect_out("idle_low", 1'b0, 4'd0, 16'h0000);
        i_tag_ready = 1'b1;
        tick();
        expect_out("recap", 1'b1, 4'd0, 16'h00F0);

        // Scroll up to index 7
        for (int d = 1; d <= 29; d++) begin
            tick();
            k = d / TICK_DIV;
            expect_out("scroll2", 1'b1, 4'(k), model_disp(k));
        end
`endif

        // Scenario 5: asynchronous reset between edges, ready held high
        @(negedge clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, 4'd0, 16'h0000);
        ->chk_ev;
        tick();
        expect_out("reset_held", 1'b0, 4'd0, 16'h0000);
        i_reset_n = 1'b1;
        tick();
        expect_out("cap_after_reset", 1'b1, 4'd0, 16'h00F0);

        tick();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks left unconsumed, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
